// File: rtl/serial_xfer32.sv
// serial_xfer32: full-duplex 32-bit serial transfer engine.
// A word is accepted on in_valid & in_ready and parallel-loaded into a
// right-shift register. It is shifted out LSB-first on sdata, one bit every
// DIV clocks. s_in is captured into the vacated MSB on each bit strobe.
// After 32 bits the captured word appears on rx_data with a one-cycle done.
//   clk, rst_n         clock, async active-low reset
//   in_valid/in_ready  word handshake (ready only while idle)
//   tx_data            word to send, sampled on the accept edge
//   s_in / sdata       serial receive / transmit bit
//   frame, bit_strobe  transfer window, last cycle of each bit period
//   done, rx_data      completion pulse, captured word
module serial_xfer32 #(
  parameter int unsigned DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] tx_data,
  input  logic        s_in,
  output logic        sdata,
  output logic        frame,
  output logic        bit_strobe,
  output logic        done,
  output logic [31:0] rx_data
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'd31;

  state_t      state;
  state_t      state_next;
  logic [31:0] shreg;
  logic [31:0] shifted;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;

  assign shifted = {s_in, shreg[31:1]};
  assign sdata   = shreg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake and framing outputs are decoded from the state register only,
  // so no input reaches in_ready, frame or done combinationally.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    frame      = 1'b0;
    done       = 1'b0;
    bit_strobe = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        frame      = 1'b1;
        bit_strobe = (div_cnt == DIV_LAST);
        if ((div_cnt == DIV_LAST) && (bit_cnt == BIT_LAST)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      rx_data <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg   <= tx_data;
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            shreg   <= shifted;
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              rx_data <= shifted;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_xfer32.sv
module tb_serial_xfer32;

  typedef struct {
    int          inst;
    logic [31:0] tx;
    logic [31:0] rx;
    int          t;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv      [3];
  logic [31:0] txd     [3];
  logic        sin_drv [3];
  logic        sin     [3];
  logic        loop1;
  logic        rdy     [3];
  logic        sd      [3];
  logic        fr      [3];
  logic        bs      [3];
  logic        dn      [3];
  logic [31:0] rxd     [3];

  int   divs [3] = '{4, 1, 3};
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  txn_t q [$];

  assign sin[0] = sin_drv[0];
  assign sin[1] = loop1 ? sd[1] : sin_drv[1];
  assign sin[2] = sin_drv[2];

  serial_xfer32 #(.DIV(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
    .tx_data(txd[0]), .s_in(sin[0]), .sdata(sd[0]), .frame(fr[0]),
    .bit_strobe(bs[0]), .done(dn[0]), .rx_data(rxd[0])
  );

  serial_xfer32 #(.DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
    .tx_data(txd[1]), .s_in(sin[1]), .sdata(sd[1]), .frame(fr[1]),
    .bit_strobe(bs[1]), .done(dn[1]), .rx_data(rxd[1])
  );

  serial_xfer32 #(.DIV(3)) u_div3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]),
    .tx_data(txd[2]), .s_in(sin[2]), .sdata(sd[2]), .frame(fr[2]),
    .bit_strobe(bs[2]), .done(dn[2]), .rx_data(rxd[2])
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (rdy[i] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(rdy[i]), 32'd1);
  endtask

  task automatic push(input int i, input logic [31:0] w, input logic [31:0] rxe, input int t);
    txn_t e;
    e.inst = i;
    e.tx   = w;
    e.rx   = rxe;
    e.t    = t;
    q.push_back(e);
  endtask

  task automatic send(input int i, input logic [31:0] w, input logic [31:0] rxe, output int t);
    wait_ready(i);
    iv[i]  = 1'b1;
    txd[i] = w;
    @(posedge clk);
    #1;
    t = cyc;
    push(i, w, rxe, t);
    iv[i]  = 1'b0;
    txd[i] = ~w;
  endtask

  // Monitor: sample mid-cycle; d counts cycles since the accept edge.
  always @(negedge clk) begin
    logic act [3];
    int   i;
    int   d;
    int   dv;
    for (int k = 0; k < 3; k++) act[k] = 1'b0;
    for (int j = q.size() - 1; j >= 0; j--) begin
      i  = q[j].inst;
      dv = divs[i];
      d  = cyc - q[j].t;
      if (d >= 0 && d <= 32 * dv) begin
        act[i] = 1'b1;
        if (d < 32 * dv) begin
          chk("frame", 32'(fr[i]), 32'd1);
          chk("sdata", 32'(sd[i]), 32'(q[j].tx[d / dv]));
          chk("strobe", 32'(bs[i]), 32'((d % dv) == dv - 1));
          chk("done_early", 32'(dn[i]), 32'd0);
          chk("busy_ready", 32'(rdy[i]), 32'd0);
        end else begin
          chk("done", 32'(dn[i]), 32'd1);
          chk("rx_data", rxd[i], q[j].rx);
          chk("frame_end", 32'(fr[i]), 32'd0);
          chk("strobe_end", 32'(bs[i]), 32'd0);
          chk("ready_done", 32'(rdy[i]), 32'd0);
          q.delete(j);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (!act[k]) begin
        chk("idle_frame", 32'(fr[k]), 32'd0);
        chk("idle_done", 32'(dn[k]), 32'd0);
      end
    end
  end

  initial begin
    int          t;
    int          n;
    logic [31:0] pat;

    rst_n = 1'b0;
    loop1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i]      = 1'b1;
      txd[i]     = 32'hCAFE_F00D;
      sin_drv[i] = 1'b0;
    end

    // Reset held with in_valid high: reset values, nothing accepted.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", 32'(rdy[i]), 32'd1);
      chk("rst_sdata", 32'(sd[i]), 32'd0);
      chk("rst_strobe", 32'(bs[i]), 32'd0);
      chk("rst_rx", rxd[i], 32'd0);
      iv[i] = 1'b0;
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("rel_ready", 32'(rdy[i]), 32'd1);

    // Basic transmit, DIV=4.
    send(0, 32'hA5A5_0F0F, 32'h0000_0000, t);
    wait_ready(0);

    // Loopback, DIV=1, with ready-return timing.
    loop1 = 1'b1;
    send(1, 32'h1234_5678, 32'h1234_5678, t);
    wait_ready(1);
    chk("ready_rise", 32'(cyc - t), 32'd33);
    loop1 = 1'b0;

    // Busy ignore: in_valid stays high; second word accepted exactly at T+130.
    sin_drv[0] = 1'b1;
    wait_ready(0);
    iv[0]  = 1'b1;
    txd[0] = 32'h0000_0001;
    @(posedge clk);
    #1;
    t = cyc;
    push(0, 32'h0000_0001, 32'hFFFF_FFFF, t);
    push(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t + 130);
    txd[0] = 32'hFFFF_FFFF;
    repeat (130) @(posedge clk);
    #1;
    iv[0]  = 1'b0;
    txd[0] = 32'h0;
    wait_ready(0);

    // Mid-transfer reset after strobe 10.
    sin_drv[0] = 1'b0;
    send(0, 32'hFFFF_FFFF, 32'h0, t);
    repeat (44) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("abort_frame", 32'(fr[0]), 32'd0);
    chk("abort_sdata", 32'(sd[0]), 32'd0);
    chk("abort_rx", rxd[0], 32'd0);
    chk("abort_ready", 32'(rdy[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sin_drv[0] = 1'b1;
    send(0, 32'h8000_0001, 32'hFFFF_FFFF, t);
    wait_ready(0);
    sin_drv[0] = 1'b0;

    // Receive pattern, DIV=3: one s_in bit per bit period.
    pat = 32'hDEAD_BEEF;
    send(2, 32'h0F1E_2D3C, 32'hDEAD_BEEF, t);
    for (int k = 0; k < 32; k++) begin
      sin_drv[2] = pat[k];
      repeat (3) @(posedge clk);
      #1;
    end
    wait_ready(2);

    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_xfer32.md
# serial_xfer32

Full-duplex 32-bit serial transfer engine sitting directly around the team's 32-bit right-shift register. A word is accepted by valid/ready handshake and parallel-loaded. It is shifted out LSB-first on `sdata` at a programmable bit rate. At the same time it captures `s_in` into the vacated MSB. After 32 bit periods the captured word is presented on `rx_data` with a one-cycle `done` pulse. The shift register is implemented inside this block; the engine is used wherever a parallel word must cross a 1-bit link.

## Interface
Parameters:
- `DIV`, 4, clock cycles per bit period; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `tx_data` is valid.
- `in_ready`  out  1  engine can accept a word (high only in IDLE).
- `tx_data`  in  32  word to transmit; LSB is sent first.
- `s_in`  in  1  serial receive bit, sampled on the bit strobe.
- `sdata`  out  1  serial transmit bit; equals shift register bit 0.
- `frame`  out  1  high for the whole 32-bit transfer window.
- `bit_strobe`  out  1  one-cycle pulse in the last cycle of each bit period.
- `done`  out  1  one-cycle pulse after the 32nd bit.
- `rx_data`  out  32  captured word; updated only when a transfer completes.

## Operation
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1, `frame`=0.
  - On `in_valid & in_ready` at edge T: shift register ← `tx_data`, `div_cnt` ← 0, `bit_cnt` ← 0, state → SHIFT.
- SHIFT:
  - `frame`=1; `div_cnt` counts 0..DIV-1.
  - `bit_strobe` = (`div_cnt`==DIV-1).
  - On a strobe edge: shift register ← {`s_in`, Q[31:1]} (shift right, `s_in` enters bit 31); `bit_cnt` increments; `div_cnt` ← 0.
  - On the strobe where `bit_cnt`==31: state → DONE, `rx_data` ← {`s_in`, Q[31:1]}.
- DONE: lasts exactly 1 cycle.
  - `done`=1, `frame`=0, `in_ready`=0.
  - Next state: IDLE.
- `in_valid` while `in_ready`=0 is ignored; no word is latched or queued.
- `tx_data` is sampled only on the accept edge; later changes have no effect.
- Counter widths: `bit_cnt` 5 bits, `div_cnt` 8 bits. No wrap-around beyond the stated terminal values.
- DIV=1: `bit_strobe` is high on every SHIFT cycle, giving one bit per clock.
- Reset asserted mid-transfer:
  - Aborts immediately; no `done` is produced.
  - `rx_data` returns to 0; the partial word is discarded.
- Reset values:
  - state IDLE, shift register 0, `rx_data` 0.
  - `sdata` 0, `frame` 0, `bit_strobe` 0, `done` 0, `in_ready` 1.
  - All counters 0.

## Timing
- Accept at edge T. From T+1, `frame`=1 and `sdata`=`tx_data[0]` for DIV cycles.
- Bit k is on `sdata` during cycles T+1+k·DIV .. T+(k+1)·DIV.
- `bit_strobe` k is high in cycle T+(k+1)·DIV; `s_in` is sampled at the end of that cycle. Receive bit k lands in `rx_data[k]`.
- `frame` falls and `done`=1 in cycle T+32·DIV+1. `rx_data` is valid from that cycle and holds until the next `done`.
- `in_ready` rises in cycle T+32·DIV+2. Minimum word period is 32·DIV+2 cycles.
- `sdata` after DONE holds the last register bit 0 (the captured `rx_data[0]`). Downstream qualifies `sdata` with `frame`.
- All outputs are registered or decoded from registered state; there is no combinational path from the inputs to `in_ready`, `done` or `frame`.

## Test plan
- Reset: `rst_n`=0 for 3 cycles with `in_valid`=1 → all outputs at reset values, `in_ready`=1, no accept; release → `in_ready`=1.
- Basic TX, DIV=4: send 0xA5A5_0F0F with `s_in`=0 → `sdata` sequence LSB-first 1,1,1,1,0,0,0,0,… each held 4 cycles; 32 strobes; `done` at T+129; `rx_data`=0x0000_0000.
- Loopback, DIV=1: tie `s_in`=`sdata`, send 0x1234_5678 → `rx_data`=0x1234_5678; `done` at T+33; `in_ready` back at T+34.
- Busy ignore: assert `in_valid` with 0xFFFF_FFFF throughout a transfer of 0x0000_0001 → only 0x0000_0001 is transmitted; 0xFFFF_FFFF is accepted at the first cycle `in_ready`=1 after `done`.
- Mid-transfer reset: reset asserted after strobe 10 → `frame`=0 and `sdata`=0 immediately; no `done` pulse; next transfer completes normally.
- Receive pattern: `s_in` driven with 0xDEAD_BEEF bits LSB-first, one per bit period (DIV=3) → `rx_data`=0xDEAD_BEEF at `done`.
